// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth derivation, pointer width and parameter checks.
package fifo_pkg;

  localparam int FIFO_MAX_AW = 8;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  function automatic int fifo_ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic bit fifo_cfg_ok(input int aw, input int af, input int ae);
    return (aw >= 1) && (aw <= FIFO_MAX_AW) &&
           (af >= 1) && (af <= fifo_depth(aw)) &&
           (ae >= 0) && (ae <= fifo_depth(aw) - 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Wrap-bit pointers, accept logic, occupancy and status flags.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THR     = fifo_depth(ADDR_WIDTH) - 1,
  parameter int AE_THR     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  write,
  input  logic                  read,
  output logic                  push_ok,
  output logic                  pop_ok,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full
);

  localparam int PW = fifo_ptr_w(ADDR_WIDTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign count = wr_ptr - rd_ptr;

  assign almost_empty = (count <= PW'(AE_THR));
  assign almost_full  = (count >= PW'(AF_THR));

  // Flush cycles accept nothing so storage and read data stay put.
  assign push_ok = write & ~full & ~flush;
  assign pop_ok  = read & ~empty & ~flush;

  assign wr_addr = wr_ptr[PW-2:0];
  assign rd_addr = rd_ptr[PW-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with FWFT option, flush and sticky errors.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter bit FWFT       = 1'b0,
  parameter int AF_THR     = fifo_depth(ADDR_WIDTH) - 1,
  parameter int AE_THR     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  if (!fifo_cfg_ok(ADDR_WIDTH, AF_THR, AE_THR)) begin : g_bad_cfg
    $error("fifo_sync_param: illegal parameter set");
  end

  logic                  push_ok;
  logic                  pop_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  fifo_ptr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_THR     (AF_THR),
    .AE_THR     (AE_THR)
  ) u_ptr (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .write        (write),
    .read         (read),
    .push_ok      (push_ok),
    .pop_ok       (pop_ok),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full)
  );

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_addr] <= write_data;
  end

  if (FWFT) begin : g_fwft
    // Masked while empty so reset shows zero instead of stale storage.
    assign read_data = empty ? '0 : mem[rd_addr];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rd_q <= '0;
      else if (pop_ok) rd_q <= mem[rd_addr];
    end
    assign read_data = rd_q;
  end

  logic ovf_set;
  logic udf_set;

  assign ovf_set = ~flush & write & full;
  assign udf_set = ~flush & read & empty;

  // Set wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= udf_set | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised and directed checks of fifo_sync_param against a queue model.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       write = 1'b0;
  logic [7:0] write_data = '0;
  logic       read = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] rd0, rd1;
  logic       empty0, full0, ae0, af0, ovf0, udf0;
  logic       empty1, full1, ae1, af1, ovf1, udf1;
  logic [2:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic [7:0] m_rd;
  bit         m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .write(write),
    .write_data(write_data), .read(read), .read_data(rd0),
    .empty(empty0), .full(full0), .almost_empty(ae0),
    .almost_full(af0), .count(cnt0), .clr_err(clr_err),
    .overflow(ovf0), .underflow(udf0)
  );

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .write(write),
    .write_data(write_data), .read(read), .read_data(rd1),
    .empty(empty1), .full(full1), .almost_empty(ae1),
    .almost_full(af1), .count(cnt1), .clr_err(clr_err),
    .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd  = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(cnt0), 32'(n));
    chk({tag, ".empty"}, 32'(empty0), 32'(n == 0));
    chk({tag, ".full"},  32'(full0),  32'(n == 4));
    chk({tag, ".ae"},    32'(ae0),    32'(n <= 1));
    chk({tag, ".af"},    32'(af0),    32'(n >= 3));
    chk({tag, ".ovf"},   32'(ovf0),   32'(m_ovf));
    chk({tag, ".udf"},   32'(udf0),   32'(m_udf));
    chk({tag, ".rd"},    32'(rd0),    32'(m_rd));
    chk({tag, ".f_cnt"}, 32'(cnt1),   32'(n));
    chk({tag, ".f_emp"}, 32'(empty1), 32'(n == 0));
    chk({tag, ".f_ovf"}, 32'(ovf1),   32'(m_ovf));
    chk({tag, ".f_udf"}, 32'(udf1),   32'(m_udf));
    if (n != 0) chk({tag, ".f_rd"}, 32'(rd1), 32'(q[0]));
  endtask

  task automatic step(input string tag, input bit w, input logic [7:0] wd,
                      input bit r, input bit fl, input bit ce);
    bit was_full, was_empty, ov_new, ud_new;
    write = w; write_data = wd; read = r; flush = fl; clr_err = ce;
    @(posedge clk);
    was_full  = (q.size() == 4);
    was_empty = (q.size() == 0);
    ov_new = !fl && w && was_full;
    ud_new = !fl && r && was_empty;
    m_ovf = ov_new | (m_ovf & !ce);
    m_udf = ud_new | (m_udf & !ce);
    if (fl) q.delete();
    else begin
      if (r && !was_empty) m_rd = q.pop_front();
      if (w && !was_full) q.push_back(wd);
    end
    #1;
    write = 1'b0; read = 1'b0; flush = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("t1_p1", 1, 8'h11, 0, 0, 0);
    step("t1_p2", 1, 8'h22, 0, 0, 0);
    step("t1_p3", 1, 8'h33, 0, 0, 0);
    chk("t1_af_at3", 32'(af0), 32'd1);
    step("t1_p4", 1, 8'h44, 0, 0, 0);
    chk("t1_full", 32'(full0), 32'd1);
    step("t1_p5", 1, 8'h55, 0, 0, 0);
    chk("t1_ovf", 32'(ovf0), 32'd1);

    step("t2_r1", 0, 8'h00, 1, 0, 0);
    chk("t2_d1", 32'(rd0), 32'h11);
    step("t2_r2", 0, 8'h00, 1, 0, 0);
    step("t2_r3", 0, 8'h00, 1, 0, 0);
    step("t2_r4", 0, 8'h00, 1, 0, 0);
    chk("t2_d4", 32'(rd0), 32'h44);
    step("t2_r5", 0, 8'h00, 1, 0, 0);
    chk("t2_udf", 32'(udf0), 32'd1);
    chk("t2_hold", 32'(rd0), 32'h44);

    step("t3_push", 1, 8'hA5, 0, 0, 0);
    chk("t3_fwft", 32'(rd1), 32'hA5);
    step("t3_pop", 0, 8'h00, 1, 0, 0);
    chk("t3_empty", 32'(empty1), 32'd1);

    step("t4_a", 1, 8'h01, 0, 0, 0);
    step("t4_b", 1, 8'h02, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step($sformatf("t4_wr%0d", i), 1, 8'h77, 1, 0, 0);
      chk("t4_cnt2", 32'(cnt0), 32'd2);
    end

    step("t5_a", 1, 8'h10, 0, 0, 0);
    step("t5_b", 1, 8'h20, 0, 0, 0);
    step("t5_ovf", 1, 8'h30, 0, 0, 0);
    step("t5_pop", 0, 8'h00, 1, 0, 0);
    chk("t5_cnt3", 32'(cnt0), 32'd3);
    step("t5_flush", 1, 8'hEE, 0, 1, 0);
    chk("t5_flush_cnt", 32'(cnt0), 32'd0);
    chk("t5_flush_ovf", 32'(ovf0), 32'd1);
    step("t5_clr", 0, 8'h00, 0, 0, 1);
    chk("t5_clr_ovf", 32'(ovf0), 32'd0);

    step("t6_a", 1, 8'hC1, 0, 0, 0);
    step("t6_b", 1, 8'hC2, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    chk("t6_rd0", 32'(rd0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("t6_push", 1, 8'hD4, 0, 0, 0);
    chk("t6_cnt1", 32'(cnt0), 32'd1);

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 99) < 55), 8'($urandom),
           1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 99) < 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
